// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, ALU codes, FSM states, instruction field positions and decode helpers
package proc_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_INV = 4'h5, OP_LDI = 4'h8, OP_INC = 4'hA,
                         OP_DEC = 4'hB, OP_HLT = 4'hC, OP_JNZ = 4'hE, OP_JMP = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR  = 3'd3, ALU_XOR = 3'd4, ALU_INV = 3'd5;
  localparam int OP_LSB = 12, RD_LSB = 8, RS1_LSB = 4, RS2_LSB = 0, IMM_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  function automatic logic is_alu(input logic [3:0] op);
    return op <= OP_INV;
  endfunction
  function automatic logic reads_rd(input logic [3:0] op);
    return op == OP_INC || op == OP_DEC || op == OP_JNZ;
  endfunction
  function automatic logic writes_rd(input logic [3:0] op);
    return is_alu(op) || op == OP_LDI || op == OP_INC || op == OP_DEC;
  endfunction
  function automatic logic is_undef(input logic [3:0] op);
    return op == 4'h6 || op == 4'h7 || op == 4'h9 || op == 4'hD;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational ALU
//   code: 3-bit operation select; a, b: operands; y: result (wraps modulo 2^DATA_W)
module alu import proc_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        code,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  assign y = code == ALU_ADD ? a + b :
             code == ALU_SUB ? a - b :
             code == ALU_AND ? a & b :
             code == ALU_OR  ? a | b :
             code == ALU_XOR ? a ^ b :
             code == ALU_INV ? ~a : '0;
endmodule

// File: rtl/proc_seq.sv
// proc_seq: fetch-decode-execute sequencer with 4-entry register file
//   clk, rst_n: clock and async active-low reset
//   start: run request (ignored while busy); imem_addr/imem_rd/imem_data: instruction fetch,
//   data valid the cycle after imem_rd; dbg_addr/dbg_data: combinational register read;
//   pc, busy, halted: status; illegal: one-cycle pulse in EXEC on an undefined opcode
module proc_seq import proc_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_rd,
  input  logic [15:0]       imem_data,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);
  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] a, b, res, alu_y;
  logic              take;
  logic [2:0]        alu_code;
  logic [3:0]        op, dop;
  logic [PC_W-1:0]   npc;
  logic              unused_ir;
  assign op        = ir[OP_LSB +: 4];
  assign dop       = imem_data[OP_LSB +: 4];
  // INC/DEC reuse the adder/subtractor with B forced to 1 at decode
  assign alu_code  = is_alu(op) ? op[2:0] : (op == OP_DEC ? ALU_SUB : ALU_ADD);
  assign npc       = take ? PC_W'(ir[IMM_LSB +: 8]) : pc + PC_W'(1);
  assign dbg_data  = regs[dbg_addr];
  assign unused_ir = ^ir[11:10];
  alu #(.DATA_W(DATA_W)) u_alu (.code(alu_code), .a(a), .b(b), .y(alu_y));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      imem_addr <= '0;
      imem_rd   <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      res       <= '0;
      take      <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) begin
          state     <= S_FETCH;
          pc        <= '0;
          imem_addr <= '0;
          imem_rd   <= 1'b1;
          busy      <= 1'b1;
          halted    <= 1'b0;
        end
        S_FETCH: begin
          imem_rd <= 1'b0;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          ir      <= imem_data;
          a       <= regs[reads_rd(dop) ? imem_data[RD_LSB +: 2] : imem_data[RS1_LSB +: 2]];
          b       <= (dop == OP_INC || dop == OP_DEC) ? DATA_W'(1) : regs[imem_data[RS2_LSB +: 2]];
          illegal <= is_undef(dop);
          state   <= S_EXEC;
        end
        S_EXEC: begin
          illegal <= 1'b0;
          res     <= op == OP_LDI ? DATA_W'(ir[IMM_LSB +: 8]) : alu_y;
          take    <= op == OP_JMP || (op == OP_JNZ && a != '0);
          if (op == OP_HLT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else state <= S_WB;
        end
        S_WB: begin
          if (writes_rd(op)) regs[ir[RD_LSB +: 2]] <= res;
          pc        <= npc;
          imem_addr <= npc;
          imem_rd   <= 1'b1;
          state     <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_seq.sv
// tb_proc_seq: directed and random programs checked against an ISA-level interpreter
module tb_proc_seq;
  logic        clk, rst_n, start, imem_rd, busy, halted, illegal;
  logic [7:0]  imem_addr, pc, dbg_data;
  logic [15:0] imem_data;
  logic [1:0]  dbg_addr;
  logic [15:0] mem [256];
  logic [7:0]  mr [4];
  int          checks = 0, errors = 0;
  int          m_trace[$], m_ill[$], dut_trace[$], dut_ill[$];
  int          m_n, dut_k, busy_low;
  proc_seq #(.DATA_W(8), .PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc),
    .busy(busy), .halted(halted), .illegal(illegal)
  );
  initial clk = 0;
  always #10 clk = ~clk;
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];
  function automatic logic [15:0] enc_r(input logic [3:0] o, input logic [1:0] d, s1, s2);
    return {o, 2'b00, d, 2'b00, s1, 2'b00, s2};
  endfunction
  function automatic logic [15:0] enc_i(input logic [3:0] o, input logic [1:0] d, input logic [7:0] imm);
    return {o, 2'b00, d, imm};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
  endtask
  task automatic clear_model();
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
  endtask
  // Interprets the program one instruction at a time; regs persist across runs
  task automatic model_run(input int maxsteps);
    logic [7:0] p;
    logic [15:0] w;
    logic [3:0] o;
    logic [1:0] d, s1, s2;
    m_trace.delete();
    m_ill.delete();
    m_n = 0;
    p = 0;
    for (int s = 0; s < maxsteps; s++) begin
      w = mem[p];
      m_trace.push_back(int'(p));
      o = w[15:12]; d = w[9:8]; s1 = w[5:4]; s2 = w[1:0];
      if (o == 4'hC) break;
      case (o)
        4'h0: mr[d] = mr[s1] + mr[s2];
        4'h1: mr[d] = mr[s1] - mr[s2];
        4'h2: mr[d] = mr[s1] & mr[s2];
        4'h3: mr[d] = mr[s1] | mr[s2];
        4'h4: mr[d] = mr[s1] ^ mr[s2];
        4'h5: mr[d] = ~mr[s1];
        4'h8: mr[d] = w[7:0];
        4'hA: mr[d] = mr[d] + 8'd1;
        4'hB: mr[d] = mr[d] - 8'd1;
        4'hE, 4'hF: ;
        default: m_ill.push_back(4 * m_n + 2);
      endcase
      p = (o == 4'hF || (o == 4'hE && mr[d] != 0)) ? w[7:0] : p + 8'd1;
      m_n++;
    end
  endtask
  // Called at a negedge; k counts cycles from the first FETCH
  task automatic run_dut(input int maxc, input int poke);
    dut_trace.delete();
    dut_ill.delete();
    dut_k = -1;
    busy_low = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < maxc; k++) begin
      start = (k == poke);
      if (imem_rd) dut_trace.push_back(int'(pc));
      if (illegal) dut_ill.push_back(k);
      if (halted) begin
        dut_k = k;
        break;
      end
      if (!busy) busy_low++;
      @(negedge clk);
    end
    start = 0;
  endtask
  task automatic rd_reg(input int i, output logic [7:0] v);
    dbg_addr = 2'(i);
    #1;
    v = dbg_data;
  endtask
  task automatic check_run(input string tag, input bit exp_halt);
    logic [7:0] v;
    chk({tag, "_tlen"}, dut_trace.size(), m_trace.size());
    for (int i = 0; i < dut_trace.size() && i < m_trace.size(); i++)
      chk($sformatf("%s_pc%0d", tag, i), dut_trace[i], m_trace[i]);
    chk({tag, "_illn"}, dut_ill.size(), m_ill.size());
    for (int i = 0; i < dut_ill.size() && i < m_ill.size(); i++)
      chk($sformatf("%s_ill%0d", tag, i), dut_ill[i], m_ill[i]);
    if (exp_halt) begin
      chk({tag, "_halt_cyc"}, dut_k, 4 * m_n + 3);
      chk({tag, "_busy_low"}, busy_low, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_halted"}, halted, 1);
    end
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      chk($sformatf("%s_r%0d", tag, i), v, mr[i]);
    end
  endtask
  task automatic check_reset(input string tag);
    logic [7:0] v;
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_imem_rd"}, imem_rd, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      chk($sformatf("%s_r%0d", tag, i), v, 0);
    end
  endtask
  initial begin
    logic [3:0] ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'hA, 4'hB, 4'h6, 4'h7, 4'h9, 4'hD};
    logic [15:0] w;
    rst_n = 0; start = 0; dbg_addr = 0;
    clear_mem();
    clear_model();
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1;
    @(negedge clk);
    clear_mem();
    mem[0] = enc_i(4'h8, 0, 5); mem[1] = enc_i(4'h8, 1, 3); mem[2] = enc_r(4'h0, 2, 0, 1);
    model_run(64);
    run_dut(200, -1);
    check_run("add", 1);
    clear_mem();
    mem[0] = enc_i(4'h8, 0, 0); mem[1] = enc_i(4'hB, 0, 0); mem[2] = enc_r(4'h1, 1, 0, 0);
    model_run(64);
    run_dut(200, -1);
    check_run("wrap", 1);
    clear_mem();
    mem[0] = enc_i(4'h8, 3, 3); mem[1] = enc_i(4'hB, 3, 0); mem[2] = enc_i(4'hE, 3, 1);
    model_run(64);
    run_dut(200, 5);
    check_run("loop", 1);
    clear_mem();
    mem[0] = 16'h6123;
    model_run(64);
    run_dut(200, -1);
    check_run("illegal", 1);
    clear_mem();
    mem[0] = enc_i(4'hF, 0, 8'hFF); mem[255] = enc_i(4'hA, 0, 0);
    model_run(5);
    run_dut(20, -1);
    check_run("pcwrap", 0);
    rst_n = 0;
    clear_model();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    clear_mem();
    mem[0] = enc_i(4'h8, 0, 5); mem[1] = enc_i(4'h8, 1, 3); mem[2] = enc_r(4'h0, 2, 0, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    check_reset("midrst");
    clear_model();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    model_run(64);
    run_dut(200, -1);
    check_run("restart", 1);
    for (int t = 0; t < 4; t++) begin
      clear_mem();
      for (int i = 0; i < 12; i++) begin
        w = 16'($urandom);
        w[15:12] = ops[$urandom_range(0, 12)];
        mem[i] = w;
      end
      model_run(64);
      run_dut(200, -1);
      check_run($sformatf("rand%0d", t), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
